// File: rtl/mem_stage_if.sv
// Shared types and the data-memory bus interface for the memory stage.
//
// mem_stage_pkg : load/store operator and write-back mux selector enums.
// mem_stage_if  : data-memory req/gnt/rvalid bus.
//   req    master->slave  memory request
//   we     master->slave  write enable
//   addr   master->slave  word-aligned address (ADDR_WIDTH)
//   be     master->slave  byte enables
//   wdata  master->slave  lane-replicated store data
//   gnt    slave->master  request accepted
//   rvalid slave->master  response valid (read data or write ack)
//   rdata  slave->master  read word
package mem_stage_pkg;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} load_store_func_code_t;
  typedef enum logic [1:0] {
    EX_RESULT_SELECT, LOAD_DATA_SELECT, UIMMD_SELECT, PC_SELECT
  } write_back_mux_selector_t;
endpackage

interface mem_stage_if #(parameter int ADDR_WIDTH = 32);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RISC-V core.
//
// Takes the EX-MEM buffer, runs one data-memory access per load/store over
// the req/gnt/rvalid bus, stalls upstream until the access completes,
// aligns/extends load data and registers the result into the MEM-WB buffer.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN -- misaligned LH/LHU/SH/LW/SW
// issue no request and raise bus_error instead of wrapping within the word.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ex_*                EX-MEM buffer: lsu enable/operator, store data, ALU
//                       result, ALU valid, wb mux, dest reg, PC, upper immd
//   dmem                data-memory bus (master modport)
//   stall               comb.; hold IF/ID/EX and the EX-MEM buffer
//   mem_fw_data         comb.; forwarding value back to EX (ALU result)
//   wb_*                MEM-WB buffer (registered)
//   bus_error           one-cycle pulse on timeout abort or misalign trap
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT   = 255,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_lsu_enable,
  input  load_store_func_code_t    ex_lsu_operator,
  input  logic [31:0]              ex_mem_wdata,
  input  logic [31:0]              ex_alu_result,
  input  logic                     ex_alu_valid,
  input  write_back_mux_selector_t ex_wb_mux,
  input  logic [4:0]               ex_write_reg_addr,
  input  logic [31:0]              ex_pc_addr,
  input  logic [31:0]              ex_uimmd,
  mem_stage_if.master              dmem,
  output logic                     stall,
  output logic [31:0]              mem_fw_data,
  output logic                     wb_valid,
  output write_back_mux_selector_t wb_mux,
  output logic [4:0]               wb_write_reg_addr,
  output logic [31:0]              wb_alu_result,
  output logic [31:0]              wb_load_data,
  output logic [31:0]              wb_pc_addr,
  output logic [31:0]              wb_uimmd,
  output logic                     bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic        access, trap, timeout, done, abort, req;
  logic [1:0]  lane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  assign access      = ex_lsu_enable & ex_alu_valid;
  assign timeout     = (wait_cnt == LAST_CNT);
  assign lane        = ex_alu_result[1:0];
  assign mem_fw_data = ex_alu_result;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    case (ex_lsu_operator)
      LH, LHU, SH: misaligned = lane[0];
      LW, SW:      misaligned = |lane;
      default:     misaligned = 1'b0;
    endcase
  end
  assign trap = access & misaligned;
`else
  // Low address bits beyond lane select are ignored: the access wraps in the word.
  assign trap = 1'b0;
`endif

  // Request fields come straight from the EX-MEM buffer, which the stall holds
  // stable for the whole access.
  assign dmem.req  = req;
  assign dmem.addr = {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
  assign dmem.we   = (ex_lsu_operator == SB) || (ex_lsu_operator == SH) ||
                     (ex_lsu_operator == SW);

  always_comb begin
    dmem.be    = 4'b1111;
    dmem.wdata = ex_mem_wdata;
    case (ex_lsu_operator)
      SB: begin
        dmem.be    = 4'b0001 << lane;
        dmem.wdata = {4{ex_mem_wdata[7:0]}};
      end
      SH: begin
        dmem.be    = 4'b0011 << {lane[1], 1'b0};
        dmem.wdata = {2{ex_mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension; stores write zero into load data.
  always_comb begin
    case (lane)
      2'd0:    rd_byte = dmem.rdata[7:0];
      2'd1:    rd_byte = dmem.rdata[15:8];
      2'd2:    rd_byte = dmem.rdata[23:16];
      default: rd_byte = dmem.rdata[31:24];
    endcase
    rd_half = lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (ex_lsu_operator)
      LB:      load_ext = {{24{rd_byte[7]}}, rd_byte};
      LBU:     load_ext = {24'd0, rd_byte};
      LH:      load_ext = {{16{rd_half[15]}}, rd_half};
      LHU:     load_ext = {16'd0, rd_half};
      LW:      load_ext = dmem.rdata;
      default: load_ext = 32'd0;
    endcase
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    req        = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (access && !trap) begin
          req        = 1'b1;
          stall      = 1'b1;
          next_state = dmem.gnt ? WAIT : REQ;
        end
      end
      REQ: begin
        if (timeout) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem.gnt) next_state = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the last allowed cycle still completes.
        if (dmem.rvalid) begin
          done       = 1'b1;
          next_state = IDLE;
        end else if (timeout) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == IDLE) ? 8'd0 : wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid          <= 1'b0;
      wb_mux            <= EX_RESULT_SELECT;
      wb_write_reg_addr <= 5'd0;
      wb_alu_result     <= 32'd0;
      wb_load_data      <= 32'd0;
      wb_pc_addr        <= 32'd0;
      wb_uimmd          <= 32'd0;
      bus_error         <= 1'b0;
    end else begin
      wb_mux        <= ex_wb_mux;
      wb_alu_result <= ex_alu_result;
      wb_pc_addr    <= ex_pc_addr;
      wb_uimmd      <= ex_uimmd;
      bus_error     <= abort | trap;
      if (done) begin
        wb_valid          <= 1'b1;
        wb_write_reg_addr <= ex_write_reg_addr;
        wb_load_data      <= load_ext;
      end else if (stall || abort || trap) begin
        // Bubble: nothing retires while the access is pending or failed.
        wb_valid          <= 1'b0;
        wb_write_reg_addr <= 5'd0;
        wb_load_data      <= 32'd0;
      end else begin
        wb_valid          <= ex_alu_valid;
        wb_write_reg_addr <= ex_write_reg_addr;
        wb_load_data      <= 32'd0;
      end
    end
  end

endmodule
